// File: rtl/alu_seq.sv
// Sequenced ALU: operand latches, a one-op-at-a-time FSM with an optional BCD
// adjust cycle, and registered result/flags with a one-cycle completion pulse.
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter int DECIMAL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_to_alu_xfer,
    input  logic             db_to_alu_xfer,
    input  logic             addr_to_alu_xfer,
    input  logic [WIDTH-1:0] accumulator_in,
    input  logic [WIDTH-1:0] db_in,
    input  logic [WIDTH-1:0] address_in,
    input  logic [3:0]       op_sel,
    input  logic             op_start,
    input  logic             c_carry,
    input  logic             d_decimal,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             negative_out,
    output logic [WIDTH-1:0] accumulator_out,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] address_out
);
    localparam int NIB = WIDTH / 4;
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2, OP_ORA = 4'd3,
                           OP_EOR = 4'd4, OP_ASL = 4'd5, OP_LSR = 4'd6, OP_ROL = 4'd7,
                           OP_ROR = 4'd8, OP_INC = 4'd9, OP_DEC = 4'd10, OP_CMP = 4'd11,
                           OP_IDX = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, DADJ, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg, b_reg, c_reg;
    logic [3:0]         op_q;
    logic               cin_q, dec_q;
    logic [WIDTH-1:0]   hold_res;
    logic               hold_c, hold_v;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   bin_res;
    logic               bin_c, bin_v;
    logic [NIB-1:0][3:0] dec_res;
    logic               dec_cy, dec_c, dec_sub;
    logic               go_dadj;

    assign accumulator_out = a_reg;
    assign db_out          = b_reg;
    assign address_out     = c_reg;

    // One BCD digit: returns {carry/borrow out, corrected digit}.
    function automatic logic [4:0] bcd_nib(input logic [3:0] a, input logic [3:0] b,
                                           input logic sub, input logic ci);
        logic [4:0] t;
        logic [3:0] d;
        logic       co;
        if (sub) begin
            t  = {1'b0, a} - {1'b0, b} - {4'b0, ci};
            co = t[4];
            d  = co ? t[3:0] - 4'd6 : t[3:0];
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {4'b0, ci};
            co = (t > 5'd9);
            d  = co ? t[3:0] + 4'd6 : t[3:0];
        end
        return {co, d};
    endfunction

    always_comb begin
        sum     = '0;
        bin_res = a_reg;
        bin_c   = cin_q;
        bin_v   = 1'b0;
        case (op_q)
            OP_ADC: begin
                sum     = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, cin_q};
                bin_res = sum[MSB:0];
                bin_c   = sum[WIDTH];
                bin_v   = (a_reg[MSB] == b_reg[MSB]) && (sum[MSB] != a_reg[MSB]);
            end
            OP_SBC: begin
                sum     = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, cin_q};
                bin_res = sum[MSB:0];
                bin_c   = sum[WIDTH];
                bin_v   = (a_reg[MSB] != b_reg[MSB]) && (sum[MSB] != a_reg[MSB]);
            end
            OP_AND: bin_res = a_reg & b_reg;
            OP_ORA: bin_res = a_reg | b_reg;
            OP_EOR: bin_res = a_reg ^ b_reg;
            OP_ASL: begin bin_res = {b_reg[MSB-1:0], 1'b0};  bin_c = b_reg[MSB]; end
            OP_LSR: begin bin_res = {1'b0, b_reg[MSB:1]};    bin_c = b_reg[0];   end
            OP_ROL: begin bin_res = {b_reg[MSB-1:0], cin_q}; bin_c = b_reg[MSB]; end
            OP_ROR: begin bin_res = {cin_q, b_reg[MSB:1]};   bin_c = b_reg[0];   end
            OP_INC: bin_res = b_reg + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_DEC: bin_res = b_reg - {{(WIDTH-1){1'b0}}, 1'b1};
            OP_CMP: begin
                sum     = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
                bin_res = sum[MSB:0];
                bin_c   = sum[WIDTH];
            end
            OP_IDX: begin
                sum     = {1'b0, c_reg} + {1'b0, b_reg};
                bin_res = sum[MSB:0];
                bin_c   = sum[WIDTH];
            end
            default: ;
        endcase
    end

    // Decimal chain runs per digit from the latched operands; SBC ripples a borrow.
    always_comb begin
        dec_sub = (op_q == OP_SBC);
        dec_cy  = dec_sub ? ~cin_q : cin_q;
        dec_res = '0;
        for (int i = 0; i < NIB; i++) begin
            {dec_cy, dec_res[i]} = bcd_nib(a_reg[4*i +: 4], b_reg[4*i +: 4], dec_sub, dec_cy);
        end
        dec_c = dec_sub ? ~dec_cy : dec_cy;
    end

    assign go_dadj = (DECIMAL_EN != 0) && dec_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            c_reg        <= '0;
            op_q         <= '0;
            cin_q        <= 1'b0;
            dec_q        <= 1'b0;
            hold_res     <= '0;
            hold_c       <= 1'b0;
            hold_v       <= 1'b0;
            result_out   <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            zero_out     <= 1'b0;
            negative_out <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        result_out   <= hold_res;
                        carry_out    <= hold_c;
                        overflow_out <= hold_v;
                        zero_out     <= (hold_res == '0);
                        negative_out <= hold_res[MSB];
                        result_valid <= 1'b1;
                    end
                    if (acc_to_alu_xfer)  a_reg <= accumulator_in;
                    if (db_to_alu_xfer)   b_reg <= db_in;
                    if (addr_to_alu_xfer) c_reg <= address_in;
                    if (op_start) begin
                        op_q  <= op_sel;
                        cin_q <= c_carry;
                        dec_q <= d_decimal;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    hold_res <= bin_res;
                    hold_c   <= bin_c;
                    hold_v   <= bin_v;
                    if (go_dadj) begin
                        state <= DADJ;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DADJ: begin
                    // V stays from the binary sum; only result and carry are adjusted.
                    hold_res <= dec_res;
                    hold_c   <= dec_c;
                    state    <= DONE;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (8-bit decimal, 8-bit binary-only, 16-bit
// decimal) against a cycle-level behavioural model plus literal spot checks.
module tb_alu_seq;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic        acc_x = 0, db_x = 0, addr_x = 0, op_start = 0, cin = 0, dec = 0;
    logic [15:0] acc_in = 0, db_in = 0, addr_in = 0;
    logic [3:0]  op_sel = 0;

    logic [2:0]  busy_o, valid_o, c_o, v_o, z_o, n_o;
    logic [15:0] res_o [3];
    logic [15:0] acc_o [3];
    logic [15:0] db_o  [3];
    logic [15:0] addr_o[3];

    int pass_cnt = 0, total_cnt = 0;

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W  = (k == 2) ? 16 : 8;
        localparam int DE = (k == 1) ? 0 : 1;
        logic [W-1:0] r, a, b, c;
        alu_seq #(.WIDTH(W), .DECIMAL_EN(DE)) dut (
            .clk(clk), .reset(reset),
            .acc_to_alu_xfer(acc_x), .db_to_alu_xfer(db_x), .addr_to_alu_xfer(addr_x),
            .accumulator_in(acc_in[W-1:0]), .db_in(db_in[W-1:0]), .address_in(addr_in[W-1:0]),
            .op_sel(op_sel), .op_start(op_start), .c_carry(cin), .d_decimal(dec),
            .busy(busy_o[k]), .result_valid(valid_o[k]), .result_out(r),
            .carry_out(c_o[k]), .overflow_out(v_o[k]), .zero_out(z_o[k]), .negative_out(n_o[k]),
            .accumulator_out(a), .db_out(b), .address_out(c));
        assign res_o[k]  = 16'(r);
        assign acc_o[k]  = 16'(a);
        assign db_o[k]   = 16'(b);
        assign addr_o[k] = 16'(c);
    end

    task automatic chk(input string nm, input logic [79:0] act_v, input logic [79:0] exp_v);
        total_cnt++;
        if (act_v !== exp_v) $display("FAIL %s: got %h want %h", nm, act_v, exp_v);
        else pass_cnt++;
    endtask

    function automatic logic [69:0] act(input int k);
        return {busy_o[k], valid_o[k], c_o[k], v_o[k], z_o[k], n_o[k],
                res_o[k], acc_o[k], db_o[k], addr_o[k]};
    endfunction

    function automatic logic [19:0] fr(input int k);
        return {c_o[k], v_o[k], z_o[k], n_o[k], res_o[k]};
    endfunction

    function automatic logic [15:0] msk(input int w);
        logic [16:0] m;
        m = (17'd1 << w) - 17'd1;
        return m[15:0];
    endfunction

    function automatic int bcd2int(input logic [15:0] x, input int w);
        int v = 0;
        for (int i = w/4 - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int t, input int w);
        logic [15:0] y = '0;
        int u = t;
        for (int i = 0; i < w/4; i++) begin
            y[4*i +: 4] = 4'(u % 10);
            u = u / 10;
        end
        return y;
    endfunction

    // Operation semantics straight from the op table; decimal via integer BCD values.
    function automatic void alu_model(input int w, input bit de, input logic [3:0] op,
                                      input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic ci, input logic d,
                                      output logic [15:0] r, output logic [3:0] f,
                                      output int lt);
        logic [16:0] s;
        logic [15:0] mk, nb;
        logic fc, fv;
        int m, da, db2, t, lim;
        mk = msk(w); nb = ~b & mk; m = w - 1;
        fc = ci; fv = 1'b0; r = a; lt = 2;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b} + {16'b0, ci}; r = s[15:0] & mk;
                        fc = s[w]; fv = (a[m] == b[m]) && (r[m] != a[m]); end
            4'd1: begin s = {1'b0, a} + {1'b0, nb} + {16'b0, ci}; r = s[15:0] & mk;
                        fc = s[w]; fv = (a[m] != b[m]) && (r[m] != a[m]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = (b << 1) & mk; fc = b[m]; end
            4'd6: begin r = b >> 1; fc = b[0]; end
            4'd7: begin r = ((b << 1) | {15'b0, ci}) & mk; fc = b[m]; end
            4'd8: begin r = b >> 1; r[m] = ci; fc = b[0]; end
            4'd9: r = (b + 16'd1) & mk;
            4'd10: r = (b - 16'd1) & mk;
            4'd11: begin r = (a - b) & mk; fc = (a >= b); end
            4'd12: begin s = {1'b0, c} + {1'b0, b}; r = s[15:0] & mk; fc = (s > {1'b0, mk}); end
            default: ;
        endcase
        if (de && d && (op <= 4'd1)) begin
            lt = 3; lim = 1;
            for (int i = 0; i < w/4; i++) lim = lim * 10;
            da = bcd2int(a, w); db2 = bcd2int(b, w);
            if (op == 4'd0) begin
                t = da + db2 + int'(ci); fc = (t >= lim); if (fc) t = t - lim;
            end else begin
                t = da - db2 - (1 - int'(ci)); fc = (t >= 0); if (!fc) t = t + lim;
            end
            r = int2bcd(t, w);
        end
        f = {fc, fv, (r == 16'h0), r[m]};
    endfunction

    int          wd [3] = '{8, 8, 16};
    bit          den[3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ea[3], eb[3], ec[3], er[3], pr[3];
    logic [3:0]  ef[3], pf[3];
    int          lat[3], acc_at[3], valid_at[3], free_at[3];
    bit          ebusy[3], evalid[3];
    int          cyc = 0;
    int          vcount[3] = '{0, 0, 0};
    int          l[3];

    // Timing model: op accepted at edge n is busy until edge n+L-1, valid at n+L;
    // new ops and transfers are accepted from edge n+L (the completion edge) on.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                ea[k] = '0; eb[k] = '0; ec[k] = '0; er[k] = '0; ef[k] = '0;
                pr[k] = '0; pf[k] = '0; lat[k] = 2; acc_at[k] = -100;
                valid_at[k] = -1; free_at[k] = 0; ebusy[k] = 0; evalid[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                evalid[k] = (cyc == valid_at[k]);
                if (evalid[k]) begin er[k] = pr[k]; ef[k] = pf[k]; end
                if (cyc >= free_at[k]) begin
                    if (acc_x)  ea[k] = acc_in  & msk(wd[k]);
                    if (db_x)   eb[k] = db_in   & msk(wd[k]);
                    if (addr_x) ec[k] = addr_in & msk(wd[k]);
                    if (op_start) begin
                        alu_model(wd[k], den[k], op_sel, ea[k], eb[k], ec[k], cin, dec,
                                  pr[k], pf[k], lat[k]);
                        acc_at[k] = cyc; free_at[k] = cyc + lat[k]; valid_at[k] = cyc + lat[k];
                    end
                end
                ebusy[k] = (cyc >= acc_at[k]) && (cyc < acc_at[k] + lat[k] - 1);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cyc%0d u%0d", cyc, k), 80'(act(k)),
                    80'({ebusy[k], evalid[k], ef[k], er[k], ea[k], eb[k], ec[k]}));
                if (valid_o[k]) vcount[k]++;
            end
        end
    end

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(negedge clk);
        acc_in = a; db_in = b; addr_in = c; acc_x = 1; db_x = 1; addr_x = 1;
        @(posedge clk); #2;
        acc_x = 0; db_x = 0; addr_x = 0;
    endtask

    task automatic run(input logic [3:0] o, input logic ci, input logic d);
        @(negedge clk);
        op_sel = o; cin = ci; dec = d; op_start = 1;
        @(posedge clk); #2;
        op_start = 0;
        for (int k = 0; k < 3; k++) l[k] = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #2;
            for (int k = 0; k < 3; k++) if (valid_o[k] && l[k] == 0) l[k] = i;
        end
    endtask

    int v0;

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("reset u%0d", k), 80'(act(k)), 80'h0);
        reset = 0;

        load(16'h50, 16'h50, 16'h0);  run(4'd0, 1'b0, 1'b0);
        chk("adc50 u0", 80'(fr(0)), 80'({4'b0101, 16'h00A0}));
        chk("adc50 lat", 80'(l[0]), 80'd2);

        load(16'h58, 16'h46, 16'h0);  run(4'd0, 1'b1, 1'b1);
        chk("dadc u0", 80'(fr(0)), 80'({4'b1100, 16'h0005}));
        chk("dadc lat u0", 80'(l[0]), 80'd3);
        chk("dadc lat u1", 80'(l[1]), 80'd2);

        load(16'h12, 16'h21, 16'h0);  run(4'd1, 1'b1, 1'b1);
        chk("dsbc u0", 80'(fr(0)), 80'({4'b0001, 16'h0091}));
        chk("bsbc u1", 80'(fr(1)), 80'({4'b0001, 16'h00F1}));
        chk("bsbc lat u1", 80'(l[1]), 80'd2);

        load(16'h0, 16'h01, 16'h0);   run(4'd8, 1'b1, 1'b0);
        chk("ror u0", 80'(fr(0)), 80'({4'b1001, 16'h0080}));

        load(16'h10, 16'h10, 16'h0);  run(4'd11, 1'b0, 1'b0);
        chk("cmp u0", 80'(fr(0)), 80'({4'b1010, 16'h0000}));

        load(16'h0, 16'h20, 16'hF0);  run(4'd12, 1'b0, 1'b0);
        chk("idx u0", 80'(fr(0)), 80'({4'b1000, 16'h0010}));
        chk("idx u2", 80'(fr(2)), 80'({4'b0000, 16'h0110}));

        load(16'h11, 16'h22, 16'h33);
        chk("xfer3 u0", 80'({acc_o[0], db_o[0], addr_o[0]}), 80'({16'h11, 16'h22, 16'h33}));

        load(16'hC3, 16'h5A, 16'h81);
        for (int o = 2; o < 16; o++) run(4'(o), o[0], 1'b0);

        // op_start and a db strobe held into EXEC must both be dropped
        load(16'h01, 16'h02, 16'h0);
        v0 = vcount[0];
        @(negedge clk); op_sel = 4'd0; cin = 0; dec = 0; op_start = 1;
        @(posedge clk); #2; db_x = 1; db_in = 16'hFF;
        @(posedge clk); #2; op_start = 0; db_x = 0;
        repeat (5) @(posedge clk); #2;
        chk("ignore pulses", 80'(vcount[0] - v0), 80'd1);
        chk("ignore db", 80'(db_o[0]), 80'h0002);
        chk("ignore res", 80'(fr(0)), 80'({4'b0000, 16'h0003}));

        load(16'h0, 16'h05, 16'h0);
        v0 = vcount[0];
        @(negedge clk); op_sel = 4'd9; cin = 0; op_start = 1;
        repeat (5) @(posedge clk); #2; op_start = 0;
        repeat (5) @(posedge clk); #2;
        chk("b2b pulses", 80'(vcount[0] - v0), 80'd3);

        load(16'hFFFF, 16'h0001, 16'h0);  run(4'd0, 1'b0, 1'b0);
        chk("adc16 u2", 80'(fr(2)), 80'({4'b1010, 16'h0000}));

        // reset while the decimal instances sit in the adjust cycle
        load(16'h58, 16'h46, 16'h0);
        v0 = vcount[0];
        @(negedge clk); op_sel = 4'd0; cin = 1; dec = 1; op_start = 1;
        @(posedge clk); #2; op_start = 0;
        @(posedge clk); #2; reset = 1;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("midrst u%0d", k), 80'(act(k)), 80'h0);
        @(negedge clk); reset = 0; dec = 0; cin = 0;
        repeat (4) @(posedge clk); #2;
        chk("midrst no pulse", 80'(vcount[0] - v0), 80'd0);

        load(16'h01, 16'h02, 16'h0);  run(4'd0, 1'b0, 1'b0);
        chk("post-rst u0", 80'(fr(0)), 80'({4'b0000, 16'h0003}));
        chk("post-rst lat", 80'(l[0]), 80'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the latched 65C02 ALU.
- Operand registers A (accumulator), B (data bus) and C (address) load from independent transfer strobes.
- A registered FSM executes one operation per op_start: binary arithmetic, logic, shift and index-add, plus an extra decimal-adjust cycle for BCD ADC/SBC.
- Sits between the register file / data-bus mux and the flag register, and reports completion with a result_valid pulse.

Parameters:
WIDTH, 8, datapath width in bits; must be a multiple of 4 and at least 8.
DECIMAL_EN, 1, 1 = BCD adjust supported; 0 = d_decimal ignored and no DADJ state.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
acc_to_alu_xfer  in  1  load a_register from accumulator_in.
db_to_alu_xfer  in  1  load b_register from db_in.
addr_to_alu_xfer  in  1  load c_register from address_in.
accumulator_in  in  WIDTH  accumulator operand.
db_in  in  WIDTH  data-bus operand.
address_in  in  WIDTH  address operand.
op_sel  in  4  operation code, sampled with op_start.
op_start  in  1  request an operation.
c_carry  in  1  carry flag in, sampled with op_start.
d_decimal  in  1  decimal flag in, sampled with op_start.
busy  out  1  operation in progress.
result_valid  out  1  one-cycle completion pulse.
result_out  out  WIDTH  registered result; held until the next completion.
carry_out, overflow_out, zero_out, negative_out  out  1 each  registered flags, updated with result_out.
accumulator_out, db_out, address_out  out  WIDTH  a_register, b_register, c_register.

Behaviour:
- Reset (async, any state): a/b/c registers, result_out and all flags = 0; busy = 0; result_valid = 0; FSM = IDLE. Reset mid-operation abandons the operation with no result_valid.
- Transfers: in IDLE, each strobe loads its register independently, so all three may load on the same edge. There is no priority chain. Strobes while busy = 1 are ignored.
- FSM states IDLE -> EXEC -> (DADJ) -> DONE -> IDLE.
- IDLE: op_start at edge N captures op_sel, c_carry and d_decimal. Operand registers loaded on edge N are the values the operation uses. Next state is EXEC, and busy = 1 from edge N.
- EXEC: compute the binary result and flags into holding registers. Go to DADJ if DECIMAL_EN = 1, d_decimal was captured as 1 and op is ADC or SBC; otherwise go to DONE.
- DADJ: per-nibble BCD correction across WIDTH/4 nibbles, then go to DONE.
  - ADC: add 6 to any nibble that is >9 or produced a nibble carry; the carry ripples upward. carry_out = final decimal carry.
  - SBC: subtract 6 from any nibble that borrowed. carry_out = NOT final borrow.
- DONE: commit result_out and flags, pulse result_valid = 1 for this one cycle, busy = 0, return to IDLE.
  - Latency from the op_start edge to result_valid: 2 cycles binary, 3 cycles decimal.
  - op_start may be asserted in the DONE cycle and is accepted.
- op_start while busy = 1 (EXEC/DADJ) is ignored, not queued.
- op_sel encodings:
  - 0 ADC: A+B+C_in.
  - 1 SBC: A+~B+C_in.
  - 2 AND, 3 ORA, 4 EOR: A op B.
  - 5 ASL B: C = msb.
  - 6 LSR B: C = lsb.
  - 7 ROL B through C_in.
  - 8 ROR B through C_in.
  - 9 INC B, 10 DEC B: wrap modulo 2^WIDTH.
  - 11 CMP: A+~B+1; result_out = difference; C = A>=B unsigned.
  - 12 IDX: C_reg+B; C = wrap (page cross).
  - 13-15: reserved; result = A, flags computed from A, C = C_in.
- Flags:
  - N = result msb; Z = (result == 0). In decimal mode both come from the adjusted result.
  - V = signed overflow of the binary sum for ADC/SBC, computed before adjust. V = 0 for all other ops.
  - C = C_in for logic ops and INC/DEC.

Test Plan:
- WIDTH=8 ADC, A=8'h50, B=8'h50, C_in=0, D=0 -> result_valid 2 cycles after op_start; result 8'hA0, N=1, V=1, C=0, Z=0.
- Decimal ADC, A=8'h58, B=8'h46, C_in=1, D=1 -> result_valid after 3 cycles; result 8'h05, C=1, Z=0.
- Decimal SBC, A=8'h12, B=8'h21, C_in=1 -> result 8'h91, C=0, N=1. Repeat with DECIMAL_EN=0 -> result 8'hF1, latency 2.
- ROR, B=8'h01, C_in=1 -> 8'h80, C=1, N=1. CMP, A=8'h10, B=8'h10 -> Z=1, C=1.
- op_start and a db transfer (8'hFF) asserted during EXEC -> both ignored; single result_valid pulse; db_out unchanged. All three transfers on one idle edge -> all three registers load.
- WIDTH=16 ADC, A=16'hFFFF, B=1, C_in=0 -> 16'h0000, Z=1, C=1. Assert reset during DADJ -> no result_valid, all outputs 0, next op_start works.
